// File: rtl/lynx_tap_player.sv
// Lynx TAP playback: captures an ioctl TAP download into tape RAM and
// replays it as a square-wave EAR stream, muxed with the ADC tape input.
module lynx_tap_player #(
  parameter int          ADDR_W    = 16,
  parameter logic [7:0]  TAP_INDEX = 8'd1,
  parameter int          HALF0     = 1136,
  parameter int          HALF1     = 568,
  parameter int          CNT_W     = 12
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  input  logic              play,
  input  logic              stop,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  input  logic              adc_ear,
  input  logic              adc_act,
  output logic              ear,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   tap_len
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FETCH, S_BIT_HI, S_BIT_LO, S_FINISH
  } state_t;

  state_t            r_state, w_next;
  logic              r_busy, r_we, r_ovf;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_wdata, r_sh;
  logic [ADDR_W:0]   r_len, r_ptr;
  logic [2:0]        r_bitcnt;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_tap_dl, w_playing, w_oob, w_wr_ok, w_cnt_z;
  logic [ADDR_W:0]   w_end, w_ptr_inc;

  // Counter holds remaining cycles minus one, so zero marks the last cycle.
  function automatic logic [CNT_W-1:0] f_half(input logic b);
    return b ? CNT_W'(HALF1 - 1) : CNT_W'(HALF0 - 1);
  endfunction

  assign w_tap_dl  = ioctl_download && (ioctl_index == TAP_INDEX);
  assign w_playing = (r_state == S_FETCH) || (r_state == S_BIT_HI) ||
                     (r_state == S_BIT_LO);
  assign w_oob     = |ioctl_addr[24:ADDR_W];
  assign w_wr_ok   = (r_state == S_LOAD) && ioctl_wr && !w_oob;
  assign w_cnt_z   = (r_cnt == '0);
  assign w_end     = {1'b0, ioctl_addr[ADDR_W-1:0]} +
                     {{ADDR_W{1'b0}}, 1'b1};
  assign w_ptr_inc = r_ptr + {{ADDR_W{1'b0}}, 1'b1};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_tap_dl)
          w_next = S_LOAD;
        else if (play && !stop)
          w_next = (r_len == '0) ? S_FINISH : S_FETCH;
      end
      S_LOAD: begin
        if (!ioctl_download)
          w_next = S_IDLE;
      end
      S_FETCH: begin
        if (w_tap_dl)     w_next = S_LOAD;
        else if (stop)    w_next = S_FINISH;
        else if (mem_ack) w_next = S_BIT_HI;
      end
      S_BIT_HI: begin
        if (w_tap_dl)     w_next = S_LOAD;
        else if (stop)    w_next = S_FINISH;
        else if (w_cnt_z) w_next = S_BIT_LO;
      end
      S_BIT_LO: begin
        if (w_tap_dl)
          w_next = S_LOAD;
        else if (stop)
          w_next = S_FINISH;
        else if (w_cnt_z) begin
          if (r_bitcnt != 3'd0)
            w_next = S_BIT_HI;
          else
            w_next = (w_ptr_inc < r_len) ? S_FETCH : S_FINISH;
        end
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_LOAD) || (w_next == S_FETCH) ||
                 (w_next == S_BIT_HI) || (w_next == S_BIT_LO);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_ovf   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_len   <= '0;
    end else begin
      r_we <= w_wr_ok;
      if (w_wr_ok) begin
        r_waddr <= ioctl_addr[ADDR_W-1:0];
        r_wdata <= ioctl_data;
        if (w_end > r_len)
          r_len <= w_end;
      end
      if ((r_state == S_LOAD) && ioctl_wr && w_oob)
        r_ovf <= 1'b1;
      if ((w_next == S_LOAD) && (r_state != S_LOAD)) begin
        r_len <= '0;
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_ptr    <= '0;
      r_sh     <= '0;
      r_bitcnt <= '0;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_next == S_FETCH)
            r_ptr <= '0;
        end
        S_FETCH: begin
          if (mem_ack) begin
            r_sh     <= mem_rdata;
            r_bitcnt <= 3'd7;
            r_cnt    <= f_half(mem_rdata[7]);
          end
        end
        S_BIT_HI: begin
          r_cnt <= w_cnt_z ? f_half(r_sh[7]) : r_cnt - 1'b1;
        end
        S_BIT_LO: begin
          if (!w_cnt_z)
            r_cnt <= r_cnt - 1'b1;
          else if (r_bitcnt != 3'd0) begin
            r_sh     <= {r_sh[6:0], 1'b0};
            r_bitcnt <= r_bitcnt - 1'b1;
            r_cnt    <= f_half(r_sh[6]);
          end else
            r_ptr <= w_ptr_inc;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = (r_state == S_FETCH) ? r_ptr[ADDR_W-1:0] : r_waddr;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_we;
  assign mem_rd    = (r_state == S_FETCH);
  assign busy      = r_busy;
  assign done      = (r_state == S_FINISH);
  assign overflow  = r_ovf;
  assign tap_len   = r_len;
  assign ear       = w_playing ? (r_state == S_BIT_HI) : (adc_ear & adc_act);

endmodule

// File: tb/tb_lynx_tap_player.sv
// Self-checking bench for lynx_tap_player: load, playback waveform,
// overflow, abort paths and asynchronous reset.
module tb_lynx_tap_player;

  localparam int AW = 4;
  localparam int H0 = 4;
  localparam int H1 = 8;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ioctl_download, ioctl_wr;
  logic [7:0]    ioctl_index, ioctl_data;
  logic [24:0]   ioctl_addr;
  logic          play, stop;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;
  logic          mem_we, mem_rd, mem_ack;
  logic          adc_ear, adc_act;
  logic          ear, busy, done, overflow;
  logic [AW:0]   tap_len;

  lynx_tap_player #(
    .ADDR_W(AW), .TAP_INDEX(8'd1), .HALF0(H0), .HALF1(H1), .CNT_W(4)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .play(play), .stop(stop),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .adc_ear(adc_ear), .adc_act(adc_act), .ear(ear), .busy(busy),
    .done(done), .overflow(overflow), .tap_len(tap_len)
  );

  always #5 clk_sys = ~clk_sys;

  // Tape RAM model with programmable read latency
  logic [7:0] ram [16];
  int rd_age = 0;
  int lat = 0;
  int we_cnt = 0;

  always @(posedge clk_sys) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
    rd_age <= mem_rd ? rd_age + 1 : 0;
  end

  assign mem_ack   = mem_rd && (rd_age == lat);
  assign mem_rdata = ram[mem_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  logic [7:0] bytes [20];
  int nb;

  task automatic load_bytes(input int n, input logic [7:0] idx);
    ioctl_download = 1'b1;
    ioctl_index = idx;
    tick();
    for (int i = 0; i < n; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_data = bytes[i];
      tick();
      ioctl_wr = 1'b0;
      if (idx == 8'd1 && i < 16) begin
        chk("ld_we", int'(mem_we), 1);
        chk("ld_addr", int'(mem_addr), i);
        chk("ld_data", int'(mem_wdata), int'(bytes[i]));
      end else
        chk("ld_no_we", int'(mem_we), 0);
    end
    chk("ld_busy_hi", int'(busy), (idx == 8'd1) ? 1 : 0);
    ioctl_download = 1'b0;
    tick();
    chk("ld_busy_drop", int'(busy), 0);
  endtask

  // Reference waveform from the byte list: read gap, then MSB-first bits
  task automatic play_check(input int l);
    int exp_q[$];
    int n, bad, rds;
    for (int b = 0; b < nb; b++) begin
      for (int g = 0; g <= l; g++) exp_q.push_back(0);
      for (int k = 7; k >= 0; k--) begin
        int h;
        h = bytes[b][k] ? H1 : H0;
        for (int c = 0; c < h; c++) exp_q.push_back(1);
        for (int c = 0; c < h; c++) exp_q.push_back(0);
      end
    end
    lat = l;
    play = 1'b1;
    tick();
    play = 1'b0;
    n = 0; bad = 0; rds = 0;
    while (!done && n < exp_q.size() + 40) begin
      if (n >= exp_q.size() || int'(ear) !== exp_q[n]) bad++;
      if (mem_rd) rds++;
      n++;
      tick();
    end
    chk("pb_len", n, exp_q.size());
    chk("pb_bits_wrong", bad, 0);
    chk("pb_reads", rds, nb * (l + 1));
    chk("pb_done", int'(done), 1);
    tick();
    chk("pb_done_1cyc", int'(done), 0);
  endtask

  typedef struct {
    logic ae;
    logic aa;
    logic exp;
  } mux_vec_t;

  mux_vec_t mv [4];
  int dcnt, rcnt;

  initial begin
    mv[0] = '{1'b0, 1'b0, 1'b0};
    mv[1] = '{1'b1, 1'b0, 1'b0};
    mv[2] = '{1'b0, 1'b1, 1'b0};
    mv[3] = '{1'b1, 1'b1, 1'b1};
    reset = 1'b1;
    ioctl_download = 0; ioctl_index = 0; ioctl_wr = 0;
    ioctl_addr = 0; ioctl_data = 0;
    play = 0; stop = 0; adc_ear = 0; adc_act = 0;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_len", int'(tap_len), 0);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_rd", int'(mem_rd), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_wdata", int'(mem_wdata), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      adc_ear = mv[i].ae;
      adc_act = mv[i].aa;
      #1;
      chk("ear_mux", int'(ear), int'(mv[i].exp));
    end
    adc_ear = 0; adc_act = 0;

    bytes[0] = 8'hA5; bytes[1] = 8'h00; bytes[2] = 8'hFF; nb = 3;
    load_bytes(3, 8'd1);
    chk("len3", int'(tap_len), 3);
    play_check(0);

    for (int i = 0; i < 20; i++) bytes[i] = 8'($urandom);
    begin
      int w0;
      w0 = we_cnt;
      load_bytes(20, 8'd1);
      chk("ovf_writes", we_cnt - w0, 16);
    end
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_len", int'(tap_len), 16);
    nb = 16;
    play_check(1);

    for (int r = 0; r < 5; r++) begin
      nb = int'($urandom_range(1, 5));
      for (int i = 0; i < nb; i++) bytes[i] = 8'($urandom);
      load_bytes(nb, 8'd1);
      chk("rnd_len", int'(tap_len), nb);
      chk("rnd_ovf", int'(overflow), 0);
      play_check(int'($urandom_range(0, 2)));
    end

    bytes[0] = 8'hA5; bytes[1] = 8'h00; bytes[2] = 8'hFF; nb = 3;
    load_bytes(3, 8'd1);
    lat = 0;
    play = 1'b1; tick(); play = 1'b0;
    for (int i = 0; i < 102; i++) tick();
    chk("stop_busy_pre", int'(busy), 1);
    adc_ear = 1; adc_act = 1;
    stop = 1'b1; tick(); stop = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) dcnt++;
      if (i == 1) chk("stop_ear_adc", int'(ear), 1);
      tick();
    end
    chk("stop_done_once", dcnt, 1);
    chk("stop_busy", int'(busy), 0);
    adc_ear = 0; adc_act = 0;
    play_check(0);

    play = 1'b1; tick(); play = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    ioctl_download = 1'b1; ioctl_index = 8'd1;
    tick();
    chk("abort_busy", int'(busy), 1);
    chk("abort_len", int'(tap_len), 0);
    chk("abort_rd", int'(mem_rd), 0);
    dcnt = int'(done);
    for (int i = 0; i < 3; i++) begin tick(); if (done) dcnt++; end
    ioctl_download = 1'b0;
    tick();
    if (done) dcnt++;
    chk("abort_no_done", dcnt, 0);
    begin
      int w0;
      w0 = we_cnt;
      load_bytes(3, 8'd2);
      chk("idx2_writes", we_cnt - w0, 0);
    end
    chk("idx2_len", int'(tap_len), 0);

    stop = 1'b1; play = 1'b1; tick(); stop = 1'b0; play = 1'b0;
    chk("playstop_done", int'(done), 0);
    chk("playstop_busy", int'(busy), 0);

    play = 1'b1; tick(); play = 1'b0;
    dcnt = 0; rcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) dcnt++;
      if (mem_rd) rcnt++;
      tick();
    end
    chk("empty_done", dcnt, 1);
    chk("empty_rd", rcnt, 0);

    bytes[0] = 8'hFF; nb = 1;
    load_bytes(1, 8'd1);
    lat = 0;
    play = 1'b1; tick(); play = 1'b0;
    tick(); tick();
    chk("pre_rst_ear", int'(ear), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_ear", int'(ear), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_rd", int'(mem_rd), 0);
    chk("arst_len", int'(tap_len), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_addr", int'(mem_addr), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
